fifo_ctrl_nch: RTL

Parametrised N-channel FIFO control logic. It supersedes the single-channel control block and adds:
- independent occupancy counters, read/write pointers and status flags per channel;
- correct simultaneous read/write handling;
- non-power-of-two depth with pointer wrap.

It sits between the channel arbiters and a shared banked memory, and drives per-channel write/read enables and addresses.

---
 rtl/fifo_ctrl_nch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_ctrl_nch.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_nch
// Description : N-channel FIFO control (pointers, occupancy, status flags)
//               for a shared banked memory. Non-power-of-two depth supported.
//               Optional macro FIFO_CTRL_STICKY_ERR_EN makes error sticky
//               until cleared by err_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_nch #(
    parameter int NUM_CH   = 4,
    parameter int MEM_SIZE = 4,
    parameter int PTR_L    = 2,
    parameter int CNT_L    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         fifo_wr,
    input  logic [NUM_CH-1:0]         fifo_rd,
    input  logic [CNT_L-1:0]          full_threshold,
    input  logic [CNT_L-1:0]          empty_threshold,
    input  logic [NUM_CH-1:0]         err_clr,
    output logic [NUM_CH-1:0]         wr_en,
    output logic [NUM_CH-1:0]         rd_en,
    output logic [NUM_CH*PTR_L-1:0]   wr_ptr,
    output logic [NUM_CH*PTR_L-1:0]   rd_ptr,
    output logic [NUM_CH*CNT_L-1:0]   count,
    output logic [NUM_CH-1:0]         fifo_full,
    output logic [NUM_CH-1:0]         fifo_empty,
    output logic [NUM_CH-1:0]         almost_full,
    output logic [NUM_CH-1:0]         almost_empty,
    output logic [NUM_CH-1:0]         error
);

    localparam logic [PTR_L-1:0] c_PTR_LAST = PTR_L'(MEM_SIZE - 1);
    localparam logic [CNT_L-1:0] c_CNT_FULL = CNT_L'(MEM_SIZE);

`ifndef FIFO_CTRL_STICKY_ERR_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = ^err_clr;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PTR_L-1:0] r_wr_ptr;
        logic [PTR_L-1:0] r_rd_ptr;
        logic [CNT_L-1:0] r_count;
        logic [CNT_L-1:0] w_count_next;
        logic [PTR_L-1:0] w_wr_ptr_inc;
        logic [PTR_L-1:0] w_rd_ptr_inc;
        logic             r_full;
        logic             r_empty;
        logic             r_afull;
        logic             r_aempty;
        logic             r_error;
        logic             w_wr_acc;
        logic             w_rd_acc;
        logic             w_reject;

        // A full FIFO still takes a write when a read frees a slot in the same cycle.
        assign w_wr_acc = fifo_wr[i] & (~r_full | fifo_rd[i]);
        assign w_rd_acc = fifo_rd[i] & ~r_empty;
        assign w_reject = (fifo_wr[i] & ~w_wr_acc) | (fifo_rd[i] & ~w_rd_acc);

        // Explicit wrap so non-power-of-two depths never address past the last entry.
        assign w_wr_ptr_inc = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_L'(1);
        assign w_rd_ptr_inc = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_L'(1);

        always_comb begin
            w_count_next = r_count;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_next = r_count + CNT_L'(1);
                2'b01:   w_count_next = r_count - CNT_L'(1);
                default: w_count_next = r_count;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_full   <= 1'b0;
                r_empty  <= 1'b1;
                r_afull  <= 1'b0;
                r_aempty <= 1'b1;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= w_wr_ptr_inc;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
                r_count  <= w_count_next;
                r_full   <= (w_count_next == c_CNT_FULL);
                r_empty  <= (w_count_next == '0);
                r_afull  <= (w_count_next >= full_threshold);
                r_aempty <= (w_count_next <= empty_threshold);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_error <= 1'b0;
            end else begin
`ifdef FIFO_CTRL_STICKY_ERR_EN
                // A rejection in the clearing cycle keeps the flag set.
                r_error <= w_reject | (r_error & ~err_clr[i]);
`else
                r_error <= w_reject;
`endif
            end
        end

        assign wr_en[i]                   = w_wr_acc;
        assign rd_en[i]                   = w_rd_acc;
        assign wr_ptr[i*PTR_L +: PTR_L]   = r_wr_ptr;
        assign rd_ptr[i*PTR_L +: PTR_L]   = r_rd_ptr;
        assign count[i*CNT_L +: CNT_L]    = r_count;
        assign fifo_full[i]               = r_full;
        assign fifo_empty[i]              = r_empty;
        assign almost_full[i]             = r_afull;
        assign almost_empty[i]            = r_aempty;
        assign error[i]                   = r_error;
    end

endmodule
`default_nettype wire
